// File: rtl/product_accumulator.sv
// product_accumulator: sums each group of COUNT unsigned products into an
// ACC_W-bit result with a sticky carry flag, handed downstream over valid/ready.
module product_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow
);

    localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_flag;
    logic [ACC_W-1:0]  r_out_sum;
    logic              r_out_overflow;

    logic              w_in_accept;
    logic              w_out_accept;
    logic              w_last;
    logic [ACC_W:0]    w_sum_ext;
    logic              w_carry;

    // Handshake flags come from the state register only; rst gating keeps
    // every output low while reset is asserted.
    assign in_ready     = (r_state == ST_ACCUM) && !rst;
    assign out_valid    = (r_state == ST_HOLD);
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_overflow;

    assign w_in_accept  = in_valid && (r_state == ST_ACCUM);
    assign w_out_accept = out_ready && (r_state == ST_HOLD);
    assign w_last       = (r_count == LAST_CNT);
    assign w_sum_ext    = {1'b0, r_acc} + {{(ACC_W - PROD_W + 1){1'b0}}, in_product};
    assign w_carry      = w_sum_ext[ACC_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: close a group on its last accept, release on output accept
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_in_accept && w_last) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_out_accept)          w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    // Accumulator datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc          <= '0;
            r_count        <= '0;
            r_flag         <= 1'b0;
            r_out_sum      <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_in_accept) begin
            if (w_last) begin
                r_out_sum      <= w_sum_ext[ACC_W-1:0];
                r_out_overflow <= r_flag | w_carry;
                r_acc          <= '0;
                r_count        <= '0;
                r_flag         <= 1'b0;
            end else begin
                r_acc   <= w_sum_ext[ACC_W-1:0];
                r_count <= r_count + 1'b1;
                r_flag  <= r_flag | w_carry;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, narrow (ACC_W=16, COUNT=2)
// and single-product (COUNT=1) instances sharing clock and reset.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_overflow;
    logic [15:0] a_in_product = '0;
    logic [23:0] a_out_sum;
    // Instance B: ACC_W=16, COUNT=2
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_overflow;
    logic [15:0] b_in_product = '0;
    logic [15:0] b_out_sum;
    // Instance C: COUNT=1
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_out_overflow;
    logic [15:0] c_in_product = '0;
    logic [23:0] c_out_sum;

    product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_product(a_in_product),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_overflow(a_out_overflow)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(16), .COUNT(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_overflow(b_out_overflow)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(1)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_product(c_in_product),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_sum(c_out_sum), .out_overflow(c_out_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] prods [4] = '{16'h0140, 16'h0850, 16'h0140, 16'h0850};
    int          bub   [4] = '{0, 1, 3, 2};

    initial begin
        // Reset state
        #2;
        check("rst_a_in_ready",  32'(a_in_ready),     32'h0);
        check("rst_a_out_valid", 32'(a_out_valid),    32'h0);
        check("rst_a_out_sum",   32'(a_out_sum),      32'h0);
        check("rst_a_out_ovf",   32'(a_out_overflow), 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        check("post_rst_a_in_ready",  32'(a_in_ready),  32'h1);
        check("post_rst_a_out_valid", 32'(a_out_valid), 32'h0);
        check("post_rst_b_in_ready",  32'(b_in_ready),  32'h1);
        check("post_rst_c_in_ready",  32'(c_in_ready),  32'h1);

        // Test 1: back-to-back group
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_product = prods[i];
            step();
        end
        a_in_valid = 1'b0;
        check("t1_out_valid", 32'(a_out_valid),    32'h1);
        check("t1_out_sum",   32'(a_out_sum),      32'h001320);
        check("t1_out_ovf",   32'(a_out_overflow), 32'h0);
        check("t1_in_ready",  32'(a_in_ready),     32'h0);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("t1_release_valid", 32'(a_out_valid), 32'h0);
        check("t1_release_ready", 32'(a_in_ready),  32'h1);
        check("t1_sum_holds",     32'(a_out_sum),   32'h001320);

        // Test 2: same group with bubbles
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b0;
            repeat (bub[i]) step();
            if (i == 3) check("t2_no_early_valid", 32'(a_out_valid), 32'h0);
            a_in_valid = 1'b1; a_in_product = prods[i];
            step();
        end
        a_in_valid = 1'b0;
        check("t2_out_valid", 32'(a_out_valid),    32'h1);
        check("t2_out_sum",   32'(a_out_sum),      32'h001320);
        check("t2_out_ovf",   32'(a_out_overflow), 32'h0);

        // Test 3: stalled result, products offered throughout must be ignored
        a_in_valid = 1'b1; a_in_product = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_valid", 32'(a_out_valid), 32'h1);
            check("t3_hold_sum",   32'(a_out_sum),   32'h001320);
            check("t3_hold_ready", 32'(a_in_ready),  32'h0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("t3_release_ready", 32'(a_in_ready),  32'h1);
        check("t3_release_valid", 32'(a_out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_product = 16'h0001;
            step();
        end
        a_in_valid = 1'b0;
        check("t3_fresh_valid", 32'(a_out_valid), 32'h1);
        check("t3_fresh_sum",   32'(a_out_sum),   32'h000004);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;

        // Test 4: wrap-around and sticky overflow, cleared for next group
        b_in_valid = 1'b1; b_in_product = 16'hFE01;
        step();
        check("t4_mid_valid", 32'(b_out_valid), 32'h0);
        step();
        b_in_valid = 1'b0;
        check("t4_valid", 32'(b_out_valid),    32'h1);
        check("t4_sum",   32'(b_out_sum),      32'h0000FC02);
        check("t4_ovf",   32'(b_out_overflow), 32'h1);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_product = 16'h0001;
        step(); step();
        b_in_valid = 1'b0;
        check("t4_next_valid", 32'(b_out_valid),    32'h1);
        check("t4_next_sum",   32'(b_out_sum),      32'h00000002);
        check("t4_next_ovf",   32'(b_out_overflow), 32'h0);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;

        // Test 6: COUNT=1, every accept yields a result
        c_in_valid = 1'b1; c_in_product = 16'h0005;
        step();
        c_in_valid = 1'b0;
        check("t6_first_valid", 32'(c_out_valid), 32'h1);
        check("t6_first_sum",   32'(c_out_sum),   32'h000005);
        c_out_ready = 1'b1;
        step();
        c_out_ready = 1'b0;
        check("t6_release_ready", 32'(c_in_ready), 32'h1);
        c_in_valid = 1'b1; c_in_product = 16'h0007;
        step();
        c_in_valid = 1'b0;
        check("t6_second_valid", 32'(c_out_valid), 32'h1);
        check("t6_second_sum",   32'(c_out_sum),   32'h000007);
        c_out_ready = 1'b1;
        step();
        c_out_ready = 1'b0;

        // Test 5: reset mid-group discards the partial sum
        a_in_valid = 1'b1; a_in_product = 16'h0001;
        step();
        a_in_product = 16'h0002;
        step();
        a_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_in_ready",  32'(a_in_ready),     32'h0);
        check("t5_rst_out_valid", 32'(a_out_valid),    32'h0);
        check("t5_rst_out_sum",   32'(a_out_sum),      32'h0);
        check("t5_rst_out_ovf",   32'(a_out_overflow), 32'h0);
        check("t5_rst_c_out_sum", 32'(c_out_sum),      32'h0);
        step();
        rst = 1'b0;
        step();
        check("t5_post_ready", 32'(a_in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_product = 16'h0001;
            step();
        end
        a_in_valid = 1'b0;
        check("t5_valid", 32'(a_out_valid),    32'h1);
        check("t5_sum",   32'(a_out_sum),      32'h000004);
        check("t5_ovf",   32'(a_out_overflow), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
